// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bit-level engines: FSM states, bit-count limits and synchronizer depth.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    DONE      = 2'd3
  } i2c_state_t;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] BIT_MODE_CNT  = 4'd1;
  localparam logic [CNT_W-1:0] BYTE_MODE_CNT = 4'd8;

  localparam int SYNC_DEPTH = 2;

  function automatic logic [CNT_W-1:0] target_count(input logic byte_mode);
    return byte_mode ? BYTE_MODE_CNT : BIT_MODE_CNT;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizer (+ optional stable-count filter when I2C_READ_GLITCH_FILTER_EN is defined) for one I2C line.
// Everything resets to 1 so that releasing reset on an idle bus never looks like an edge.
module i2c_line_sync
  import i2c_pkg::*;
#(
  parameter int FILTER_DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic line_s,
  output logic line_p
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  synced;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], line_i};
    end
  end

  assign synced = sync_q[SYNC_DEPTH-1];

`ifdef I2C_READ_GLITCH_FILTER_EN
  localparam int FCNT_W = $clog2(FILTER_DEPTH + 1);

  logic [FCNT_W-1:0] stable_cnt;
  logic              filt_q;

  // The filtered level only follows after FILTER_DEPTH consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q     <= 1'b1;
      stable_cnt <= '0;
    end else if (synced == filt_q) begin
      stable_cnt <= '0;
    end else if (stable_cnt == FCNT_W'(FILTER_DEPTH - 1)) begin
      filt_q     <= synced;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign line_s = filt_q;
`else
  assign line_s = synced;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_p <= 1'b1;
    end else begin
      line_p <= line_s;
    end
  end

endmodule

// File: rtl/i2c_read.sv
// I2C receive engine: samples SDA on SCL rises into a bit or byte and watches for START/STOP/bus errors.
// Optional input glitch filtering is enabled with the macro I2C_READ_GLITCH_FILTER_EN.
module i2c_read
  import i2c_pkg::*;
#(
  parameter int FILTER_DEPTH = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rd_en,
  input  logic       is_byte,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       rd_ld,
  output logic       data_o,
  output logic [7:0] data_byte,
  output logic       rd_finish,
  output logic       get_start,
  output logic       get_stop,
  output logic       bus_err
);

  logic scl_s, scl_p, sda_s, sda_p;

  i2c_line_sync #(.FILTER_DEPTH(FILTER_DEPTH)) u_scl_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_i (scl_i),
    .line_s (scl_s),
    .line_p (scl_p)
  );

  i2c_line_sync #(.FILTER_DEPTH(FILTER_DEPTH)) u_sda_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_i (sda_i),
    .line_s (sda_s),
    .line_p (sda_p)
  );

  // SDA edges only count while SCL has been high for two samples, so an SCL edge always wins.
  logic scl_rise, scl_fall, scl_high, sda_fall_hi, sda_rise_hi;

  assign scl_rise    = scl_s & ~scl_p;
  assign scl_fall    = ~scl_s & scl_p;
  assign scl_high    = scl_s & scl_p;
  assign sda_fall_hi = scl_high & ~sda_s & sda_p;
  assign sda_rise_hi = scl_high & sda_s & ~sda_p;

  i2c_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             byte_mode_q, byte_mode_d;
  logic [7:0]       byte_d;
  logic             bit_d, ld_d, fin_d, err_d;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_mode_d = byte_mode_q;
    byte_d      = data_byte;
    bit_d       = data_o;
    ld_d        = 1'b0;
    fin_d       = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rd_en) begin
          byte_mode_d = is_byte;
          cnt_d       = '0;
          byte_d      = '0;
          state_d     = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (scl_rise) begin
          bit_d   = sda_s;
          byte_d  = {data_byte[6:0], sda_s};
          ld_d    = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (sda_fall_hi || sda_rise_hi) begin
          err_d   = 1'b1;
          fin_d   = 1'b1;
          state_d = DONE;
        end else if (scl_fall) begin
          cnt_d = cnt_inc;
          if (cnt_inc == target_count(byte_mode_q)) begin
            fin_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WAIT_RISE;
          end
        end
      end
      DONE: begin
        if (!rd_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A withdrawn request aborts silently from any active state.
    if (state_q != IDLE && !rd_en) begin
      state_d     = IDLE;
      cnt_d       = '0;
      byte_mode_d = byte_mode_q;
      byte_d      = data_byte;
      bit_d       = data_o;
      ld_d        = 1'b0;
      fin_d       = 1'b0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      byte_mode_q <= 1'b0;
      data_byte   <= '0;
      data_o      <= 1'b0;
      rd_ld       <= 1'b0;
      rd_finish   <= 1'b0;
      bus_err     <= 1'b0;
      get_start   <= 1'b0;
      get_stop    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_mode_q <= byte_mode_d;
      data_byte   <= byte_d;
      data_o      <= bit_d;
      rd_ld       <= ld_d;
      rd_finish   <= fin_d;
      bus_err     <= err_d;
      get_start   <= sda_fall_hi;
      get_stop    <= sda_rise_hi;
    end
  end

endmodule

// File: tb/tb_i2c_read.sv
// Self-checking bench for i2c_read: vector table of bit/byte reads plus abort, bus-error and START/STOP sequences.
module tb_i2c_read;

`ifdef I2C_READ_GLITCH_FILTER_EN
  localparam int HALF = 6;
  localparam int LAT  = 6;
`else
  localparam int HALF = 4;
  localparam int LAT  = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n, rd_en, is_byte, scl_i, sda_i;
  logic       rd_ld, data_o, rd_finish, get_start, get_stop, bus_err;
  logic [7:0] data_byte;

  int total = 0;
  int bad   = 0;

  i2c_read #(.FILTER_DEPTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_en),
    .is_byte   (is_byte),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .rd_ld     (rd_ld),
    .data_o    (data_o),
    .data_byte (data_byte),
    .rd_finish (rd_finish),
    .get_start (get_start),
    .get_stop  (get_stop),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  // Event monitor, sampled on the falling clock edge.
  int         cyc = 0, fin_total = 0, err_total = 0, start_total = 0, stop_total = 0, triple_total = 0;
  int         start_cyc = 0, stop_cyc = 0;
  logic [7:0] fin_byte = 8'h00;
  logic       ld_bits[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rd_ld) ld_bits.push_back(data_o);
    if (rd_finish) begin
      fin_total <= fin_total + 1;
      fin_byte  <= data_byte;
    end
    if (bus_err) err_total <= err_total + 1;
    if (get_start) begin
      start_total <= start_total + 1;
      start_cyc   <= cyc;
    end
    if (get_stop) begin
      stop_total <= stop_total + 1;
      stop_cyc   <= cyc;
    end
    if (bus_err && get_start && rd_finish) triple_total <= triple_total + 1;
  end

  int base_ld, base_fin, base_err, base_start, base_stop, base_triple;

  task automatic clearMon();
    base_ld     = ld_bits.size();
    base_fin    = fin_total;
    base_err    = err_total;
    base_start  = start_total;
    base_stop   = stop_total;
    base_triple = triple_total;
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: what an I2C read of 'value' must deliver, MSB first for bytes.
  typedef struct {
    logic       is_b;
    logic [7:0] value;
    logic [7:0] exp_byte;
    int         exp_lds;
  } vec_t;

  function automatic logic modelBit(input logic is_b, input logic [7:0] value, input int k);
    return is_b ? value[7-k] : value[0];
  endfunction

  function automatic vec_t mkVec(input logic is_b, input logic [7:0] value);
    vec_t v;
    v.is_b     = is_b;
    v.value    = value;
    v.exp_byte = is_b ? value : {7'b0, value[0]};
    v.exp_lds  = is_b ? 8 : 1;
    return v;
  endfunction

  task automatic sendBit(input logic b);
    scl_i = 1'b0;
    waitClk(HALF / 2);
    sda_i = b;
    waitClk(HALF - HALF / 2);
    scl_i = 1'b1;
    waitClk(HALF);
  endtask

  task automatic waitFinish();
    for (int i = 0; i < 40; i++) begin
      if (fin_total != base_fin) break;
      waitClk(1);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    clearMon();
    is_byte = v.is_b;
    rd_en   = 1'b1;
    waitClk(2);
    for (int k = 0; k < v.exp_lds; k++) sendBit(modelBit(v.is_b, v.value, k));
    scl_i = 1'b0;
    waitFinish();
    rd_en = 1'b0;
    waitClk(2);
  endtask

  task automatic checkVector(input string tag, input vec_t v);
    int n;
    n = ld_bits.size() - base_ld;
    checkOutput({tag, " rd_ld count"}, n, v.exp_lds);
    for (int k = 0; k < v.exp_lds && k < n; k++)
      checkOutput($sformatf("%s data_o bit%0d", tag, k), ld_bits[base_ld + k], modelBit(v.is_b, v.value, k));
    checkOutput({tag, " rd_finish count"}, fin_total - base_fin, 1);
    checkOutput({tag, " data_byte"}, fin_byte, v.exp_byte);
    checkOutput({tag, " bus_err count"}, err_total - base_err, 0);
    checkOutput({tag, " start+stop count"}, (start_total - base_start) + (stop_total - base_stop), 0);
  endtask

  function automatic logic [13:0] allOutputs();
    return {rd_ld, data_o, data_byte, rd_finish, get_start, get_stop, bus_err};
  endfunction

  vec_t vecs[9];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int   lat;
    logic found;

    rst_n = 1'b0; rd_en = 1'b0; is_byte = 1'b0; scl_i = 1'b1; sda_i = 1'b1;
    waitClk(2);
    checkOutput("reset outputs", allOutputs(), 0);
    rst_n = 1'b1;
    waitClk(4);

    vecs[0] = '{1'b1, 8'hA5, 8'hA5, 8};
    vecs[1] = '{1'b0, 8'h00, 8'h00, 1};
    vecs[2] = '{1'b0, 8'h01, 8'h01, 1};
    vecs[3] = '{1'b1, 8'hFF, 8'hFF, 8};
    vecs[4] = '{1'b1, 8'h00, 8'h00, 8};
    vecs[5] = mkVec(1'b1, 8'($urandom));
    vecs[6] = mkVec(1'b1, 8'($urandom));
    vecs[7] = mkVec(1'b0, 8'($urandom));
    vecs[8] = mkVec(1'b1, 8'($urandom));

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      checkVector($sformatf("vec%0d", i), vecs[i]);
    end

    // Latency from scl_i rise to rd_ld for a single ACK bit.
    clearMon();
    is_byte = 1'b0;
    rd_en   = 1'b1;
    waitClk(2);
    scl_i = 1'b0;
    waitClk(HALF / 2);
    sda_i = 1'b1;
    waitClk(HALF - HALF / 2);
    scl_i = 1'b1;
    lat   = 0;
    found = 1'b0;
    for (int k = 1; k <= 12 && !found; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (rd_ld) begin
        lat   = k;
        found = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    waitClk(HALF);
    scl_i = 1'b0;
    waitFinish();
    rd_en = 1'b0;
    waitClk(2);
    checkOutput("rd_ld latency", lat, LAT);
    checkOutput("latency rd_ld count", ld_bits.size() - base_ld, 1);
    checkOutput("latency data_byte", fin_byte, 8'h01);
    checkOutput("latency rd_finish count", fin_total - base_fin, 1);

    // START inside bit 3 of a byte.
    clearMon();
    is_byte = 1'b1;
    rd_en   = 1'b1;
    waitClk(2);
    sendBit(1'b1);
    sendBit(1'b1);
    sendBit(1'b0);
    scl_i = 1'b0;
    waitClk(HALF / 2);
    sda_i = 1'b1;
    waitClk(HALF - HALF / 2);
    scl_i = 1'b1;
    waitClk(HALF / 2);
    sda_i = 1'b0;
    waitClk(HALF);
    sendBit(1'b1);
    scl_i = 1'b0;
    waitClk(HALF);
    rd_en = 1'b0;
    waitClk(2);
    checkOutput("buserr rd_ld count", ld_bits.size() - base_ld, 4);
    checkOutput("buserr bus_err count", err_total - base_err, 1);
    checkOutput("buserr coincident err/start/finish", triple_total - base_triple, 1);
    checkOutput("buserr rd_finish count", fin_total - base_fin, 1);
    checkOutput("buserr get_start count", start_total - base_start, 1);

    // START then STOP with no active request.
    clearMon();
    sda_i = 1'b1;
    waitClk(HALF);
    scl_i = 1'b1;
    waitClk(HALF);
    sda_i = 1'b0;
    waitClk(HALF);
    sda_i = 1'b1;
    waitClk(HALF);
    scl_i = 1'b0;
    waitClk(HALF);
    checkOutput("idle get_start count", start_total - base_start, 1);
    checkOutput("idle get_stop count", stop_total - base_stop, 1);
    checkOutput("idle start before stop", (start_cyc < stop_cyc) ? 1 : 0, 1);
    checkOutput("idle bus_err count", err_total - base_err, 0);
    checkOutput("idle rd_ld count", ld_bits.size() - base_ld, 0);
    checkOutput("idle rd_finish count", fin_total - base_fin, 0);

    // Request withdrawn after bit 4, then a reset in the middle of the next byte.
    clearMon();
    is_byte = 1'b1;
    rd_en   = 1'b1;
    waitClk(2);
    for (int k = 0; k < 5; k++) sendBit(modelBit(1'b1, 8'h96, k));
    rd_en = 1'b0;
    waitClk(HALF);
    scl_i = 1'b0;
    waitClk(HALF);
    checkOutput("abort rd_ld count", ld_bits.size() - base_ld, 5);
    checkOutput("abort rd_finish count", fin_total - base_fin, 0);
    checkOutput("abort bus_err count", err_total - base_err, 0);
    rd_en = 1'b1;
    waitClk(2);
    sendBit(1'b1);
    sendBit(1'b0);
    scl_i = 1'b0;
    waitClk(1);
    rst_n = 1'b0;
    #1;
    checkOutput("midbyte reset outputs", allOutputs(), 0);
    waitClk(3);
    rd_en = 1'b0;
    sda_i = 1'b1;
    rst_n = 1'b1;
    waitClk(6);
    checkOutput("reset rd_finish count", fin_total - base_fin, 0);
    applyStimulus(mkVec(1'b1, 8'h3C));
    checkVector("after-reset 3C", mkVec(1'b1, 8'h3C));

`ifdef I2C_READ_GLITCH_FILTER_EN
    // Short SDA glitch while SCL is high must be filtered away.
    clearMon();
    scl_i = 1'b1;
    waitClk(HALF);
    sda_i = 1'b0;
    waitClk(2);
    sda_i = 1'b1;
    waitClk(HALF);
    scl_i = 1'b0;
    waitClk(HALF);
    checkOutput("glitch get_start count", start_total - base_start, 0);
    checkOutput("glitch bus_err count", err_total - base_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
